medi_alert_scheduler: RTL and testbench
=======================================

// Module: medi_alert_scheduler
// PURPOSE
// - Schedules pill-box alerts for the three-box (R/G/Y) medication kit once the countdown runs.
// - Holds two programmable alert seconds per box and raises a pending flag when one comes due.
// - Serves one alert at a time, using a round-robin arbiter, and counts missed doses per box.
// - Sits between the main control FSM (which drives run and cfg_*) and the LED/7-seg display logic.
// PARAMETERS
// - NBOX       3   number of boxes (index 0=R, 1=G, 2=Y); the RTL supports 3 only
// - ALERT_SEC  30  seconds an alert stays active before it counts as missed (1..63)
// - MISS_W     5   width of each missed-dose counter
// PORTS
// - clkin      in   1        system clock
// - rst_n      in   1        reset, asynchronous, active-low
// - run        in   1        1 = countdown running; main FSM in state 0101 or an alert state
// - sec_tick   in   1        one-clkin strobe per second
// - sec_now    in   6        current second, binary 0..59; valid on sec_tick
// - cfg_we     in   1        write one table slot
// - cfg_box    in   2        box index; value 3 is ignored
// - cfg_slot   in   1        slot 0 = first time, slot 1 = second time
// - cfg_time   in   6        alert second; values > 59 are written but never match
// - cfg_clr    in   1        invalidate all 6 slots and clear pend (power-off)
// - ack        in   1        one-cycle pulse, debounced b3 "dose taken"
// - snooze     in   1        one-cycle pulse; used only with MEDI_SNOOZE_EN
// - miss_clr   in   1        clear all miss counters
// - alert_oh   out  3        one-hot box currently alerting
// - pend       out  3        per-box pending flags
// - miss_cnt   out  3*MISS_W {Y,G,R} missed-dose counters, saturating
// - sch_state  out  2        00 IDLE, 01 ALERT, 10 GAP
// BEHAVIOUR
// - Reset values: all outputs 0, all slots invalid, timer 0, round-robin pointer = 2 (R served first).
// - Slot write: cfg_we stores {valid=1, cfg_time} in the selected slot on the next edge.
// - cfg_clr: has priority over cfg_we; clears pend in the same cycle.
// - Due check: on sec_tick & run, box b is due if any valid slot of b equals sec_now.
// - Due box not yet pending: pend[b] <= 1 (visible 1 cycle after the tick).
// - Due box already pending and not being served (repeat before service): miss_cnt[b] += 1; pend stays 1.
// - Due box currently in ALERT: ignored; the timer is not reloaded.
// - FSM IDLE: if run & |pend, grant the first pending box after the pointer (cyclic R->G->Y).
//   - Next edge: ALERT, alert_oh = grant, timer = ALERT_SEC, pointer = granted box.
//   - Latency: tick at edge T -> pend at T+1 -> alert_oh at T+2.
// - FSM ALERT, highest priority first:
//   - !run: go to IDLE, alert_oh = 0, pend kept, no miss counted.
//   - ack: pend[cur] <= 0, go to GAP, no miss.
//   - sec_tick with timer == 1: miss_cnt[cur] += 1, pend[cur] <= 0, go to GAP.
//   - sec_tick otherwise: timer -= 1.
//   - ack and timeout in the same cycle: ack wins.
// - FSM GAP: exactly one cycle with alert_oh = 0, then IDLE.
//   - Every alert therefore produces a visible edge, even back-to-back on the same box.
// - miss counters: saturate at 2^MISS_W-1; miss_clr overrides any same-cycle increment.
// - Due checks and increments run in every FSM state.
// - Async reset mid-ALERT: everything returns to reset values immediately.
// CONFIGURATION
// - MEDI_SNOOZE_EN defined:
//   - In ALERT, a snooze pulse with no ack reloads timer = ALERT_SEC; the alert stays active.
//   - Only one snooze is allowed per grant; a flag clears on entry to ALERT.
//   - Later snoozes are ignored. ack has priority over snooze.
// - MEDI_SNOOZE_EN undefined: the snooze port exists but is ignored; no flag register.
// TESTING
// - Slot R0=10, run=1, tick sec=10 -> pend=001 at T+1, alert_oh=001 at T+2; ack -> GAP 1 cycle, then IDLE, pend=000.
// - R0=G0=Y0=20, tick sec=20 -> pend=111; served R, G, Y in order, each acked; miss_cnt all 0.
// - ALERT_SEC=3, G0=5, no ack -> 3 ticks later miss_cnt[G]=1, pend[G]=0, then alert_oh=000.
// - ack and third timeout tick in the same cycle -> miss_cnt unchanged.
// - R pending while G is alerting, R due again -> miss_cnt[R]=1; saturation check: 31+1 stays 31.
// - run drops mid-alert -> IDLE, pend kept; run back -> same box re-granted, timer = ALERT_SEC.
// - rst_n low mid-alert -> all outputs 0 asynchronously.
// - MEDI_SNOOZE_EN: two snoozes in one alert -> the timer reloads once only; the alert times out after 2*ALERT_SEC-k ticks.

Source files
------------

// File: rtl/medi_alert_scheduler.sv
// medi_alert_scheduler: per-box alert table, round-robin alert FSM and saturating missed-dose counters; MEDI_SNOOZE_EN adds one snooze per grant
module medi_alert_scheduler #(
  parameter int NBOX      = 3,
  parameter int ALERT_SEC = 30,
  parameter int MISS_W    = 5
) (
  input  logic                   clkin,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   sec_tick,
  input  logic [5:0]             sec_now,
  input  logic                   cfg_we,
  input  logic [1:0]             cfg_box,
  input  logic                   cfg_slot,
  input  logic [5:0]             cfg_time,
  input  logic                   cfg_clr,
  input  logic                   ack,
  input  logic                   snooze,
  input  logic                   miss_clr,
  output logic [NBOX-1:0]        alert_oh,
  output logic [NBOX-1:0]        pend,
  output logic [3*MISS_W-1:0]    miss_cnt,
  output logic [1:0]             sch_state
);
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_ALERT = 2'b01, S_GAP = 2'b10} state_t;
  localparam logic [5:0] LP_SEC = 6'(ALERT_SEC);
  state_t                     r_state;
  logic [5:0]                 r_valid;
  logic [5:0][5:0]            r_time;
  logic [5:0]                 r_timer;
  logic [1:0]                 r_ptr;
  logic [NBOX-1:0]            r_alert, r_pend;
  logic [2:0][MISS_W-1:0]     r_miss, w_mnx;
  logic [NBOX-1:0]            w_due, w_srv, w_clr, w_inc, w_gnt;
  logic [1:0]                 w_c1, w_c2, w_gidx;
  logic                       w_act, w_snz, w_tout, w_done;
`ifdef MEDI_SNOOZE_EN
  logic                       r_snz;
  assign w_snz = snooze & ~r_snz;
`else
  logic                       w_unused;
  assign w_unused = snooze;
  assign w_snz    = 1'b0;
`endif
  // Service decisions for the alerting box and the cyclic grant search after the pointer
  always_comb begin
    w_act  = (r_state == S_ALERT) & run;
    w_tout = w_act & ~ack & ~w_snz & sec_tick & (r_timer == 6'd1);
    w_done = (w_act & ack) | w_tout;
    w_c1   = (r_ptr == 2'd2) ? 2'd0 : r_ptr + 2'd1;
    w_c2   = (w_c1 == 2'd2) ? 2'd0 : w_c1 + 2'd1;
    w_gidx = r_pend[w_c1] ? w_c1 : r_pend[w_c2] ? w_c2 : r_ptr;
    w_gnt  = 3'b001 << w_gidx;
  end
  for (genvar b = 0; b < 3; b++) begin : g_box
    assign w_due[b] = sec_tick & run & ((r_valid[2*b] & (r_time[2*b] == sec_now)) |
                                        (r_valid[2*b+1] & (r_time[2*b+1] == sec_now)));
    assign w_srv[b] = (r_state == S_ALERT) & r_alert[b];
    assign w_clr[b] = w_done & r_alert[b];
    assign w_inc[b] = (w_due[b] & r_pend[b] & ~w_srv[b]) | (w_tout & r_alert[b]);
    assign w_mnx[b] = miss_clr ? '0 : (w_inc[b] && r_miss[b] != '1) ? r_miss[b] + 1'b1 : r_miss[b];
  end
  // Alert-time table; box index 3 is not a real box and is dropped
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_time  <= '0;
    end else if (cfg_clr) begin
      r_valid <= '0;
    end else if (cfg_we && cfg_box != 2'd3) begin
      r_valid[{cfg_box, cfg_slot}] <= 1'b1;
      r_time[{cfg_box, cfg_slot}]  <= cfg_time;
    end
  end
  // Pending flags and missed-dose counters; the box under service ignores its own due ticks
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_miss <= '0;
    end else begin
      r_pend <= cfg_clr ? '0 : (r_pend & ~w_clr) | (w_due & ~w_srv);
      r_miss <= w_mnx;
    end
  end
  // Alert FSM: grant, hold until ack/timeout/run-drop, then one blank cycle
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_alert <= '0;
      r_timer <= '0;
      r_ptr   <= 2'd2;
`ifdef MEDI_SNOOZE_EN
      r_snz   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (run && |r_pend) begin
          r_state <= S_ALERT;
          r_alert <= w_gnt;
          r_timer <= LP_SEC;
          r_ptr   <= w_gidx;
`ifdef MEDI_SNOOZE_EN
          r_snz   <= 1'b0;
`endif
        end
        S_ALERT: if (!run) begin
          r_state <= S_IDLE;
          r_alert <= '0;
        end else if (w_done) begin
          r_state <= S_GAP;
          r_alert <= '0;
        end
`ifdef MEDI_SNOOZE_EN
        else if (w_snz) begin
          r_timer <= LP_SEC;
          r_snz   <= 1'b1;
        end
`endif
        else if (sec_tick) begin
          r_timer <= r_timer - 6'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign alert_oh  = r_alert;
  assign pend      = r_pend;
  assign miss_cnt  = r_miss;
  assign sch_state = r_state;
endmodule

// File: tb/tb_medi_alert_scheduler.sv
// tb_medi_alert_scheduler: directed and random checks of medi_alert_scheduler against a cycle model
module tb_medi_alert_scheduler;
  localparam int AS  = 3;
  localparam int MW  = 5;
  localparam int SAT = 31;
  logic        clk = 0, rst_n = 0, run = 0, sec_tick = 0, cfg_we = 0, cfg_slot = 0;
  logic        cfg_clr = 0, ack = 0, snooze = 0, miss_clr = 0;
  logic [5:0]  sec_now = 0, cfg_time = 0;
  logic [1:0]  cfg_box = 0;
  logic [2:0]  alert_oh, pend;
  logic [14:0] miss_cnt;
  logic [1:0]  sch_state;
  int checks = 0, failures = 0;
  int m_valid[6], m_time[6], m_pend[3], m_miss[3], m_mode, m_cur, m_timer, m_ptr;
  int n_valid[6], n_time[6], n_pend[3], n_miss[3], n_mode, n_cur, n_timer, n_ptr;

  medi_alert_scheduler #(.NBOX(3), .ALERT_SEC(AS), .MISS_W(MW)) dut (
    .clkin(clk), .rst_n(rst_n), .run(run), .sec_tick(sec_tick), .sec_now(sec_now),
    .cfg_we(cfg_we), .cfg_box(cfg_box), .cfg_slot(cfg_slot), .cfg_time(cfg_time),
    .cfg_clr(cfg_clr), .ack(ack), .snooze(snooze), .miss_clr(miss_clr),
    .alert_oh(alert_oh), .pend(pend), .miss_cnt(miss_cnt), .sch_state(sch_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic model_reset();
    m_valid = '{default: 0};
    m_time  = '{default: 0};
    m_pend  = '{default: 0};
    m_miss  = '{default: 0};
    m_mode  = 0;
    m_cur   = -1;
    m_timer = 0;
    m_ptr   = 2;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    model_reset();
    chk("rst_alert", 32'(alert_oh), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_miss", 32'(miss_cnt), 0);
    chk("rst_state", 32'(sch_state), 0);
    rst_n = 1;
  endtask

  task automatic step();
    int  due[3];
    int  srv;
    bit  found;
    n_valid = m_valid; n_time = m_time; n_pend = m_pend; n_miss = m_miss;
    n_mode = m_mode; n_cur = m_cur; n_timer = m_timer; n_ptr = m_ptr;
    for (int b = 0; b < 3; b++)
      due[b] = (sec_tick && run &&
               ((m_valid[2*b] != 0 && m_time[2*b] == int'(sec_now)) ||
                (m_valid[2*b+1] != 0 && m_time[2*b+1] == int'(sec_now)))) ? 1 : 0;
    srv = (m_mode == 1) ? m_cur : -1;
    if (cfg_clr) n_valid = '{default: 0};
    else if (cfg_we && cfg_box != 2'd3) begin
      n_valid[int'(cfg_box) * 2 + int'(cfg_slot)] = 1;
      n_time[int'(cfg_box) * 2 + int'(cfg_slot)]  = int'(cfg_time);
    end
    case (m_mode)
      0: if (run) begin
        found = 0;
        for (int k = 1; k <= 3; k++) begin
          int b = (m_ptr + k) % 3;
          if (!found && m_pend[b] != 0) begin
            found = 1; n_mode = 1; n_cur = b; n_timer = AS; n_ptr = b;
          end
        end
      end
      1: if (!run) begin
        n_mode = 0; n_cur = -1;
      end else if (ack) begin
        n_pend[m_cur] = 0; n_mode = 2; n_cur = -1;
      end else if (sec_tick) begin
        if (m_timer == 1) begin
          n_miss[m_cur] = sat(m_miss[m_cur]); n_pend[m_cur] = 0; n_mode = 2; n_cur = -1;
        end else n_timer = m_timer - 1;
      end
      default: n_mode = 0;
    endcase
    for (int b = 0; b < 3; b++)
      if (due[b] != 0 && b != srv) begin
        if (m_pend[b] != 0) n_miss[b] = sat(m_miss[b]);
        else n_pend[b] = 1;
      end
    if (cfg_clr) n_pend = '{default: 0};
    if (miss_clr) n_miss = '{default: 0};
    @(posedge clk);
    #1;
    m_valid = n_valid; m_time = n_time; m_pend = n_pend; m_miss = n_miss;
    m_mode = n_mode; m_cur = n_cur; m_timer = n_timer; m_ptr = n_ptr;
    chk("alert_oh", 32'(alert_oh), (m_mode == 1) ? (1 << m_cur) : 0);
    chk("pend", 32'(pend), m_pend[0] + 2 * m_pend[1] + 4 * m_pend[2]);
    chk("miss_cnt", 32'(miss_cnt), m_miss[0] + 32 * m_miss[1] + 1024 * m_miss[2]);
    chk("sch_state", 32'(sch_state), m_mode);
    sec_tick = 0; cfg_we = 0; cfg_clr = 0; ack = 0; snooze = 0; miss_clr = 0;
  endtask

  task automatic wr(input int box, input int slot, input int t);
    cfg_we = 1; cfg_box = 2'(box); cfg_slot = 1'(slot); cfg_time = 6'(t);
    step();
  endtask

  task automatic tick(input int s);
    sec_tick = 1; sec_now = 6'(s);
    step();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    // single alert latency and ack path
    wr(0, 0, 10);
    run = 1;
    tick(10);
    chk("lat_pend", 32'(pend), 1);
    chk("lat_alert_early", 32'(alert_oh), 0);
    step();
    chk("lat_alert", 32'(alert_oh), 1);
    ack = 1;
    step();
    chk("ack_gap", 32'(sch_state), 2);
    chk("ack_pend", 32'(pend), 0);
    step();
    chk("gap_idle", 32'(sch_state), 0);
    // three boxes due together are served R, G, Y
    do_reset();
    wr(0, 0, 20); wr(1, 0, 20); wr(2, 0, 20);
    tick(20);
    chk("all_pend", 32'(pend), 7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rr_order", 32'(alert_oh), 1 << i);
      ack = 1;
      step();
      step();
    end
    chk("rr_miss", 32'(miss_cnt), 0);
    // timeout on G
    wr(1, 0, 5);
    tick(5);
    step();
    chk("g_alert", 32'(alert_oh), 2);
    tick(40); tick(40); tick(40);
    chk("to_state", 32'(sch_state), 2);
    chk("to_miss", 32'(miss_cnt), 32);
    chk("to_pend", 32'(pend), 0);
    step();
    chk("to_alert", 32'(alert_oh), 0);
    // ack beats the final timeout tick
    wr(2, 0, 7);
    tick(7);
    step();
    tick(40); tick(40);
    ack = 1;
    tick(40);
    chk("ackto_state", 32'(sch_state), 2);
    chk("ackto_miss", 32'(miss_cnt), 32);
    // repeat-before-service misses and saturation
    wr(0, 1, 9); wr(1, 0, 9);
    tick(9);
    chk("rg_pend", 32'(pend), 3);
    step();
    for (int r = 0; r < 80; r++) begin
      tick(9); tick(9);
      ack = 1;
      step(); step(); step();
      if (r == 1) chk("rep_miss_r", 32'(miss_cnt[4:0]), 1);
    end
    chk("sat_r", 32'(miss_cnt[4:0]), SAT);
    chk("sat_g", 32'(miss_cnt[9:5]), SAT);
    miss_clr = 1;
    step();
    chk("miss_clr", 32'(miss_cnt), 0);
    // run drop mid-alert keeps pend and re-grants with a fresh timer
    cfg_clr = 1;
    step();
    ack = 1;
    step(); step(); step();
    chk("clr_idle", 32'(sch_state), 0);
    wr(0, 0, 10);
    tick(10);
    step();
    tick(40);
    run = 0;
    step();
    chk("drop_state", 32'(sch_state), 0);
    chk("drop_alert", 32'(alert_oh), 0);
    chk("drop_pend", 32'(pend), 1);
    run = 1;
    step();
    chk("regrant", 32'(alert_oh), 1);
    tick(40); tick(40);
    chk("reload_alive", 32'(alert_oh), 1);
    tick(40);
    chk("reload_to", 32'(miss_cnt), 1);
    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      run      = ($urandom_range(0, 9) != 0);
      sec_tick = ($urandom_range(0, 3) == 0);
      sec_now  = 6'($urandom_range(0, 9));
      cfg_we   = ($urandom_range(0, 9) == 0);
      cfg_box  = 2'($urandom_range(0, 3));
      cfg_slot = 1'($urandom_range(0, 1));
      cfg_time = 6'(($urandom_range(0, 7) == 0) ? $urandom_range(60, 63) : $urandom_range(0, 9));
      cfg_clr  = ($urandom_range(0, 79) == 0);
      ack      = ($urandom_range(0, 11) == 0);
      snooze   = ($urandom_range(0, 1) == 1);
      miss_clr = ($urandom_range(0, 149) == 0);
      step();
    end
    // asynchronous reset in the middle of an alert
    do_reset();
    run = 1;
    wr(0, 0, 10);
    tick(10);
    step();
    chk("pre_rst_alert", 32'(sch_state), 1);
    do_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
